// File: rtl/conv_xy_engine.sv
// Signed X/Y convolution engine. It computes A.B and A.B^T over a 3x3 or KMAX x KMAX
// window, using P MACs per axis per cycle, with saturating or legacy overflow handling.
module conv_xy_engine #(
    parameter int DW   = 8,
    parameter int KMAX = 5,
    parameter int P    = 2,
    parameter int ACCW = 2*DW+5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   ksize_sel,
    input  logic                   sat_mode,
    input  logic [KMAX*KMAX*DW-1:0] matrix_a,
    input  logic [KMAX*KMAX*DW-1:0] matrix_b,
    output logic [DW-1:0]          sum_x,
    output logic [DW-1:0]          sum_y,
    output logic                   ovf_x,
    output logic                   ovf_y,
    output logic                   busy,
    output logic                   ready
);

    localparam int N  = KMAX*KMAX;
    localparam int S5 = (N+P-1)/P;
    localparam int S3 = (9+P-1)/P;
    localparam int CW = $clog2(S5+1);
    localparam logic signed [ACCW-1:0] MAXV = ACCW'((2**(DW-1))-1);
    localparam logic signed [ACCW-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, SUM, DONE} state_t;

    state_t                  state_q, state_d;
    logic [N*DW-1:0]         a_q, a_d, b_q, b_d;
    logic                    ks_q, ks_d, sat_q, sat_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [ACCW-1:0]  accX_q, accX_d, accY_q, accY_d;
    logic [DW-1:0]           sumX_q, sumX_d, sumY_q, sumY_d;
    logic                    ovfX_q, ovfX_d, ovfY_q, ovfY_d;
    logic                    ready_q, ready_d;

    logic signed [ACCW-1:0]  laneX, laneY;
    logic signed [DW-1:0]    aEl, bXEl, bYEl;
    logic signed [2*DW-1:0]  prX, prY;
    logic [CW-1:0]           lastCnt;
    logic [DW:0]             finX, finY;
    int                      e, r, c;

    // Returns {ovf, result} for a finished accumulator.
    function automatic logic [DW:0] finishAcc(input logic signed [ACCW-1:0] acc,
                                              input logic sat);
        if (acc > MAXV)
            return sat ? {1'b1, 1'b0, {(DW-1){1'b1}}} : {1'b1, {DW{1'b1}}};
        else if (acc < MINV)
            return sat ? {1'b1, 1'b1, {(DW-1){1'b0}}} : {1'b1, {DW{1'b1}}};
        else
            return {1'b0, acc[DW-1:0]};
    endfunction

    // Per-cycle lane sum. For the 3x3 case the window-relative row/column are offset by 1,
    // so swapping r and c gives the transpose within the inner window.
    always_comb begin
        laneX = '0;
        laneY = '0;
        aEl   = '0;
        bXEl  = '0;
        bYEl  = '0;
        prX   = '0;
        prY   = '0;
        e     = 0;
        r     = 0;
        c     = 0;
        for (int p = 0; p < P; p++) begin
            e = int'(cnt_q)*P + p;
            if (e < (ks_q ? N : 9)) begin
                if (ks_q) begin
                    r = e / KMAX;
                    c = e % KMAX;
                end else begin
                    r = e / 3 + 1;
                    c = e % 3 + 1;
                end
                aEl   = a_q[(N-1-(r*KMAX+c))*DW +: DW];
                bXEl  = b_q[(N-1-(r*KMAX+c))*DW +: DW];
                bYEl  = b_q[(N-1-(c*KMAX+r))*DW +: DW];
                prX   = (2*DW)'(aEl) * (2*DW)'(bXEl);
                prY   = (2*DW)'(aEl) * (2*DW)'(bYEl);
                laneX = laneX + {{(ACCW-2*DW){prX[2*DW-1]}}, prX};
                laneY = laneY + {{(ACCW-2*DW){prY[2*DW-1]}}, prY};
            end
        end
    end

    assign lastCnt = ks_q ? CW'(S5-1) : CW'(S3-1);
    assign finX    = finishAcc(accX_q, sat_q);
    assign finY    = finishAcc(accY_q, sat_q);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        ks_d    = ks_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        accX_d  = accX_q;
        accY_d  = accY_q;
        sumX_d  = sumX_q;
        sumY_d  = sumY_q;
        ovfX_d  = ovfX_q;
        ovfY_d  = ovfY_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = matrix_a;
                    b_d     = matrix_b;
                    ks_d    = ksize_sel;
                    sat_d   = sat_mode;
                    cnt_d   = '0;
                    accX_d  = '0;
                    accY_d  = '0;
                    state_d = SUM;
                end
            end
            SUM: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    accX_d = accX_q + laneX;
                    accY_d = accY_q + laneY;
                    if (cnt_q == lastCnt)
                        state_d = DONE;
                    else
                        cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                {ovfX_d, sumX_d} = finX;
                {ovfY_d, sumY_d} = finY;
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            ks_q    <= 1'b0;
            sat_q   <= 1'b0;
            cnt_q   <= '0;
            accX_q  <= '0;
            accY_q  <= '0;
            sumX_q  <= '0;
            sumY_q  <= '0;
            ovfX_q  <= 1'b0;
            ovfY_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ks_q    <= ks_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
            accX_q  <= accX_d;
            accY_q  <= accY_d;
            sumX_q  <= sumX_d;
            sumY_q  <= sumY_d;
            ovfX_q  <= ovfX_d;
            ovfY_q  <= ovfY_d;
            ready_q <= ready_d;
        end
    end

    assign sum_x = sumX_q;
    assign sum_y = sumY_q;
    assign ovf_x = ovfX_q;
    assign ovf_y = ovfY_q;
    assign busy  = (state_q != IDLE);
    assign ready = ready_q;

endmodule

// File: tb/tb_conv_xy_engine.sv
// Directed self-checking bench for conv_xy_engine with KMAX=5, P=2, DW=8.
// Expected values are worked out by hand from the operand patterns.
module tb_conv_xy_engine;

    localparam int DW   = 8;
    localparam int KMAX = 5;
    localparam int NB   = KMAX*KMAX*DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, ksize_sel, sat_mode;
    logic [NB-1:0] matrix_a, matrix_b;
    logic [DW-1:0] sum_x, sum_y;
    logic          ovf_x, ovf_y, busy, ready;

    int compared   = 0;
    int mismatched = 0;
    int lat, bc;
    logic [NB-1:0] m1, m2;

    conv_xy_engine #(.DW(DW), .KMAX(KMAX), .P(2)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .ksize_sel(ksize_sel), .sat_mode(sat_mode),
        .matrix_a(matrix_a), .matrix_b(matrix_b),
        .sum_x(sum_x), .sum_y(sum_y), .ovf_x(ovf_x), .ovf_y(ovf_y),
        .busy(busy), .ready(ready)
    );

    always #5 clk = ~clk;

    function automatic logic [NB-1:0] fill(input logic [DW-1:0] v);
        logic [NB-1:0] m;
        for (int k = 0; k < KMAX*KMAX; k++) m[k*DW +: DW] = v;
        return m;
    endfunction

    function automatic logic [NB-1:0] put(input logic [NB-1:0] m, input int i, input int j,
                                          input logic [DW-1:0] v);
        logic [NB-1:0] t;
        t = m;
        t[(KMAX*KMAX-1-(i*KMAX+j))*DW +: DW] = v;
        return t;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Drives a request; the edge it waits for is edge 0 of the run.
    task automatic applyStimulus(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                 input logic ks, input logic sat);
        matrix_a  = a;
        matrix_b  = b;
        ksize_sel = ks;
        sat_mode  = sat;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_after_capture", {31'd0, busy}, 32'd1);
        checkOutput("ready_low_after_capture", {31'd0, ready}, 32'd0);
    endtask

    // kind: 0 none, 1 start pulse, 2 abort, 3 change matrix_a, 4 reset; applied at edge injectAt.
    task automatic waitReady(input int kind, input int injectAt, output int gotLat,
                             output int busyCnt);
        gotLat  = -1;
        busyCnt = 0;
        for (int n = 1; n <= 30; n++) begin
            if (n == injectAt) begin
                case (kind)
                    1: begin start = 1'b1; matrix_a = fill(8'd10); matrix_b = fill(8'd10); end
                    2: abort = 1'b1;
                    3: matrix_a = fill(8'd10);
                    4: begin
                        rst = 1'b1;
                        #2;
                        checkOutput("rst_sum_x", {24'd0, sum_x}, 32'd0);
                        checkOutput("rst_sum_y", {24'd0, sum_y}, 32'd0);
                        checkOutput("rst_ovf", {30'd0, ovf_x, ovf_y}, 32'd0);
                        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
                        checkOutput("rst_ready", {31'd0, ready}, 32'd0);
                    end
                    default: ;
                endcase
            end
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            rst   = 1'b0;
            if (ready) begin
                gotLat = n;
                break;
            end
            if (busy) busyCnt++;
        end
    endtask

    task automatic runCase(input string tag, input logic [NB-1:0] a, input logic [NB-1:0] b,
                           input logic ks, input logic sat, input int expLat,
                           input logic [7:0] expX, input logic [7:0] expY,
                           input logic expOx, input logic expOy);
        int l, bcnt;
        applyStimulus(a, b, ks, sat);
        waitReady(0, 0, l, bcnt);
        checkOutput({tag, "_latency"}, l, expLat);
        checkOutput({tag, "_busy_cycles"}, bcnt, expLat - 1);
        checkOutput({tag, "_sum_x"}, {24'd0, sum_x}, {24'd0, expX});
        checkOutput({tag, "_sum_y"}, {24'd0, sum_y}, {24'd0, expY});
        checkOutput({tag, "_ovf_x"}, {31'd0, ovf_x}, {31'd0, expOx});
        checkOutput({tag, "_ovf_y"}, {31'd0, ovf_y}, {31'd0, expOy});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; ksize_sel = 1'b0; sat_mode = 1'b0;
        matrix_a = '0; matrix_b = '0;
        #12;
        checkOutput("reset_sums", {16'd0, sum_x, sum_y}, 32'd0);
        checkOutput("reset_flags", {28'd0, ovf_x, ovf_y, busy, ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        runCase("ones5", fill(8'd1), fill(8'd1), 1'b1, 1'b1, 14, 8'd25, 8'd25, 1'b0, 1'b0);

        m1 = put(put('0, 0, 1, 8'd2), 1, 0, 8'd3);
        m2 = put('0, 0, 1, 8'd1);
        runCase("transpose", m1, m2, 1'b1, 1'b1, 14, 8'd2, 8'd3, 1'b0, 1'b0);

        runCase("sat_pos", fill(8'd10), fill(8'd10), 1'b1, 1'b1, 14, 8'h7F, 8'h7F, 1'b1, 1'b1);
        runCase("legacy", fill(8'd10), fill(8'd10), 1'b1, 1'b0, 14, 8'hFF, 8'hFF, 1'b1, 1'b1);
        runCase("sat_neg", fill(8'd10), fill(8'hF6), 1'b1, 1'b1, 14, 8'h80, 8'h80, 1'b1, 1'b1);

        m1 = fill(8'd100);
        m2 = fill(8'd100);
        for (int i = 1; i <= 3; i++)
            for (int j = 1; j <= 3; j++) begin
                m1 = put(m1, i, j, 8'd1);
                m2 = put(m2, i, j, 8'd1);
            end
        runCase("inner3", m1, m2, 1'b0, 1'b1, 6, 8'd9, 8'd9, 1'b0, 1'b0);

        m1 = put(put('0, 0, 1, 8'd127), 1, 0, 8'd1);
        m2 = put('0, 0, 1, 8'd127);
        runCase("mixed", m1, m2, 1'b1, 1'b0, 14, 8'hFF, 8'h7F, 1'b1, 1'b0);

        applyStimulus(fill(8'd1), fill(8'd1), 1'b1, 1'b1);
        waitReady(1, 3, lat, bc);
        checkOutput("start_ignored_latency", lat, 14);
        checkOutput("start_ignored_sum_x", {24'd0, sum_x}, 32'd25);

        applyStimulus(fill(8'd10), fill(8'd10), 1'b1, 1'b1);
        waitReady(2, 5, lat, bc);
        checkOutput("abort_no_ready", lat, -1);
        checkOutput("abort_busy_cycles", bc, 4);
        checkOutput("abort_keep_sum", {16'd0, sum_x, sum_y}, {16'd0, 8'd25, 8'd25});
        checkOutput("abort_keep_ovf", {30'd0, ovf_x, ovf_y}, 32'd0);

        applyStimulus(fill(8'd1), fill(8'd1), 1'b0, 1'b1);
        waitReady(3, 1, lat, bc);
        checkOutput("capture_latency", lat, 6);
        checkOutput("capture_sums", {16'd0, sum_x, sum_y}, {16'd0, 8'd9, 8'd9});

        applyStimulus(fill(8'd1), fill(8'd1), 1'b1, 1'b1);
        waitReady(4, 7, lat, bc);
        checkOutput("reset_mid_no_ready", lat, -1);
        checkOutput("reset_mid_busy_cycles", bc, 6);

        runCase("after_rst", fill(8'd1), fill(8'd1), 1'b1, 1'b1, 14, 8'd25, 8'd25, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/conv_xy_engine.md
Name: conv_xy_engine

Overview:
Parametrised successor to the single-pixel X/Y convolution unit in the matrix coprocessor datapath.
- Computes two signed dot products per request on packed KMAX x KMAX operands: the pixel window A against filter B (X axis), and A against the transpose of B (Y axis).
- Adds a runtime 3x3/5x5 kernel size, P MACs per cycle per axis, selectable saturate/legacy overflow handling, independent per-axis overflow flags, operand capture, and abort.

Parameters:
- DW, 8, signed element width for A, B and the results.
- KMAX, 5, maximum kernel dimension; operands are KMAX*KMAX elements.
- P, 2, MACs per cycle per axis (1..KMAX*KMAX).
- ACCW, 2*DW+5, signed accumulator width; must hold KMAX*KMAX full-scale products without wrap.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  request; sampled only in IDLE
- abort  in  1  synchronous cancel of an in-flight request
- ksize_sel  in  1  0 = 3x3 (inner window), 1 = KMAX x KMAX; captured with start
- sat_mode  in  1  1 = clamp to signed limits, 0 = legacy all-ones on overflow; captured with start
- matrix_a  in  KMAX*KMAX*DW  pixel window, row-major, element [0][0] in the MSBs
- matrix_b  in  KMAX*KMAX*DW  filter, same packing
- sum_x  out  DW  X result
- sum_y  out  DW  Y result
- ovf_x  out  1  X overflow flag
- ovf_y  out  1  Y overflow flag
- busy  out  1  high from the capture edge until ready
- ready  out  1  one-cycle completion pulse

Behaviour:
- Interface: reset rst, asynchronous, active-high; clock clk.
- Reset state: IDLE. sum_x = sum_y = 0, ovf_x = ovf_y = 0, busy = 0, ready = 0, accumulators and counter cleared.
- Reset mid-operation: aborts the request, no ready pulse, all outputs return to 0.
- States are IDLE, SUM and DONE.
- IDLE -> SUM:
  - On start=1, capture matrix_a, matrix_b, ksize_sel and sat_mode into internal registers.
  - Clear both accumulators and the counter; set busy=1.
  - Inputs may change afterwards without affecting the result.
- Active window:
  - ksize_sel=1: all KMAX^2 elements, E = KMAX^2.
  - ksize_sel=0: rows and columns 1..3 of the captured matrices, E = 9; the outer ring is ignored.
- Products:
  - X term: A[i][j]*B[i][j].
  - Y term: A[i][j]*B[j][i], with the transpose taken within the active window (for 3x3, indices are relative to the inner window).
  - Each product is signed 2*DW bits, sign-extended to ACCW.
- SUM:
  - Each cycle adds the next P window elements (row-major order) to each accumulator.
  - Runs S = ceil(E/P) cycles; unused lanes in the final group contribute 0.
  - Then moves to DONE.
- DONE (one cycle), evaluated per axis independently:
  - No overflow (acc within [-2^(DW-1), 2^(DW-1)-1]): result = acc[DW-1:0], ovf = 0.
  - Overflow with sat_mode=1: result = 2^(DW-1)-1 for positive acc, -2^(DW-1) for negative; ovf = 1.
  - Overflow with sat_mode=0: result = all ones; ovf = 1.
  - Registers the results, pulses ready=1 for one cycle, clears busy, returns to IDLE.
- Latency: with start high at edge 0, ready is high after edge S+1.
  - KMAX=5, P=2: 5x5 gives S=13, ready after edge 14; 3x3 gives S=5, ready after edge 6.
  - Back-to-back: a new start is accepted in the cycle ready is high.
- Output hold: sum_*/ovf_* hold until the next DONE or reset.
- start while busy: ignored, with no queuing.
- abort=1 in SUM: return to IDLE next edge, busy=0, no ready, outputs keep their previous values.
- abort=1 in IDLE: no effect.
- Simultaneous start and abort in IDLE: start wins.
- abort and rst together: rst wins.

Test Plan:
- 5x5, A all 1, B all 1, sat_mode=1 -> sum_x=25, sum_y=25, ovf_x=ovf_y=0, ready one cycle after edge 14, busy high edges 1..13.
- 5x5, all zero except A[0][1]=2, A[1][0]=3, B[0][1]=1 -> sum_x=2, sum_y=3; confirms the transpose and that the flags are independent.
- 5x5, A all 10, B all 10 (acc 2500) -> sat_mode=1: sum_x=sum_y=0x7F with ovf=1; sat_mode=0: 0xFF with ovf=1. With B all -10 and sat_mode=1 -> 0x80 with ovf=1.
- 3x3, inner A=1 and B=1, outer ring A=100 and B=100 -> sum_x=sum_y=9, ready after edge 6; the outer ring has no effect.
- Mixed overflow: B[0][1]=127, A[0][1]=127 (X: 16129) and A[1][0]=1 (Y: 127) -> ovf_x=1, ovf_y=0, sum_y=0x7F.
- Control: start pulse at edge 3 of a run -> ignored. abort at edge 5 -> no ready and previous outputs retained. Capture check: change matrix_a after start -> result unchanged. rst at edge 7 -> all outputs 0 and next start runs normally.
